// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset vector, syscall encoding and the fetch queue entry.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] SYSCALL_INST     = 32'h0000_000C;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    StFetch,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; read data is zero while empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;
  localparam logic [PtrW:0]   CntMax = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntMax);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: reads are masked by the empty flag.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, redirect and halt FSM feeding a prefetch queue.
// Halt-on-syscall detection is compiled in only when FETCH_HALT_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fifo_full, fifo_empty;
  logic         push_en, pop_en, halt_hit;
  fetch_entry_t wr_entry, rd_entry;
  logic         unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign imem_addr  = pc_q;
  assign inst_valid = !fifo_empty;
  assign pop_en     = inst_valid && inst_ready && !redirect_valid;
  assign push_en    = !redirect_valid && (state_q == StFetch) && (!fifo_full || pop_en);
  assign wr_entry   = '{pc: pc_q, inst: imem_inst};
  assign inst_out   = rd_entry.inst;
  assign inst_pc    = rd_entry.pc;

`ifdef FETCH_HALT_EN
  // The syscall itself is still enqueued; fetching stops after it.
  assign halt_hit = push_en && (imem_inst == SYSCALL_INST);
  assign halted   = (state_q == StHalt);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = StFetch;
    end else begin
      if (push_en)  pc_d    = pc_q + 32'd4;
      if (halt_hit) state_d = StHalt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_en),
    .pop  (pop_en),
    .flush(redirect_valid),
    .wdata(wr_entry),
    .rdata(rd_entry),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning first fetch byte address.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory (word-aligned).
REQ-006 SHALL have port imem_inst  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port inst_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL have port inst_out  output  32  head instruction word.
REQ-012 SHALL have port inst_pc  output  32  byte address of head instruction.
REQ-013 SHALL have port halted  output  1  fetch stopped by halt detection (see Configuration).

Function
REQ-014 SHALL drive imem_addr combinationally from the internal fetch PC register.
REQ-015 SHALL push {fetch PC, imem_inst} into the queue and advance fetch PC by 4 on a clock edge when push is enabled: queue not full, or full with a pop in the same cycle; not halted; no redirect.
REQ-016 SHALL pop the head on a clock edge when inst_valid and inst_ready are both 1.
REQ-017 SHALL allow simultaneous push and pop in one cycle, leaving the occupancy count unchanged.
REQ-018 SHALL, on redirect_valid=1, flush all queue entries, set fetch PC to {redirect_pc[31:2],2'b00}, clear halted, and perform no push that cycle; redirect SHALL take priority over push and pop.
REQ-019 SHALL wrap fetch PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-020 SHALL give a latency of one cycle from push edge to inst_valid=1 for that entry.
REQ-021 SHALL hold inst_out and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-022 SHALL use a 2-state control FSM: FETCH (pushing allowed) and HALT (no pushes; queue drains normally); FETCH->HALT per REQ-026; HALT->FETCH only on redirect or reset.

Reset
REQ-023 SHALL, while rst_n=0, force fetch PC=RESET_PC, queue empty, inst_valid=0, inst_out=0, inst_pc=0, halted=0, FSM=FETCH.
REQ-024 SHALL, if reset asserts mid-operation, discard all queued entries immediately; first push occurs on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL compile halt detection in only when FETCH_HALT_EN is defined.
REQ-026 With FETCH_HALT_EN: a pushed word equal to 32'h0000_000C (syscall) SHALL be enqueued, then the FSM SHALL enter HALT and halted SHALL read 1 from the next cycle.
REQ-027 Without FETCH_HALT_EN: the FSM SHALL never leave FETCH and halted SHALL be tied to 0.

Structure
REQ-028 SHALL place RESET_PC default, the syscall encoding, and the fetch entry type {pc, inst} in shared package cpu_pkg.
REQ-029 SHALL implement the queue as sub-module fetch_fifo (parameterised depth/width, push/pop/flush, full/empty); fetch_unit holds PC, FSM, and redirect logic.

Verification
REQ-030 Reset release, memory returns 32'h2008_0005 at 0x0040_0000 and inst_ready=1 -> inst_valid=1 one cycle later, inst_pc=32'h0040_0000, inst_out=32'h2008_0005; next entry inst_pc=32'h0040_0004.
REQ-031 inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 pushes; imem_addr holds 32'h0040_0010; head unchanged; with inst_ready=1 and full, push and pop on the same edge.
REQ-032 redirect_valid=1 with redirect_pc=32'h0040_0103 while 3 entries queued -> next cycle inst_valid=0, imem_addr=32'h0040_0100; following cycle inst_pc=32'h0040_0100.
REQ-033 Fetch PC at 32'hFFFF_FFFC, push -> imem_addr=32'h0000_0000 next.
REQ-034 FETCH_HALT_EN defined, syscall at 0x0040_0008 -> entries 0x0040_0000..0x0040_0008 delivered, halted=1, no further pushes; redirect to 0x0040_0000 clears halted; without macro, the same program keeps fetching 0x0040_000C.
REQ-035 rst_n asserted asynchronously mid-cycle with 2 entries queued -> inst_valid=0 immediately, before the next clock edge.
